// File: rtl/reaction_timer_core.sv
// Multi-player reaction-time engine: synchronised buttons, pseudo-random GO delay,
// per-player millisecond timing, false-start detection, winner and best-time record.
module reaction_timer_core #(
  parameter int N_PLAYERS        = 2,
  parameter int TIME_W           = 14,
  parameter int TICKS_PER_MS     = 50000,
  parameter int MIN_DELAY_MS     = 1000,
  parameter int DELAY_RANGE_LOG2 = 10,
  parameter int TIMEOUT_MS       = 9999
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_btn,
  input  logic [N_PLAYERS-1:0]          react_btn,
  output logic                          go,
  output logic [2:0]                    state,
  output logic [N_PLAYERS-1:0]          hit,
  output logic [N_PLAYERS-1:0]          fault,
  output logic [N_PLAYERS*TIME_W-1:0]   times,
  output logic [2:0]                    winner,
  output logic [TIME_W-1:0]             best_time,
  output logic                          done
);

  localparam int                PRE_W     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [TIME_W-1:0] TIMEOUT   = TIME_W'(TIMEOUT_MS);
  localparam logic [TIME_W-1:0] MIN_DELAY = TIME_W'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                      state_q, state_nx;
  logic [N_PLAYERS:0]          sync1, sync2, prev, btn_edge;
  logic                        start_edge, tick, entering;
  logic [N_PLAYERS-1:0]        react_edge, hit_nx;
  logic [15:0]                 lfsr;
  logic [PRE_W-1:0]            presc;
  logic [TIME_W-1:0]           ms_cnt, delay_ms, win_time;
  logic [N_PLAYERS*TIME_W-1:0] times_nx;
  logic [2:0]                  win_idx;

  // Bit 0 carries the start button, bits N_PLAYERS:1 the reaction buttons.
  assign btn_edge   = sync2 & ~prev;
  assign start_edge = btn_edge[0];
  assign react_edge = btn_edge[N_PLAYERS:1];
  assign tick       = (presc == PRE_LAST);
  assign entering   = (state_nx != state_q);
  assign state      = state_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latches).
    state_nx = state_q;
    hit_nx   = hit;
    times_nx = times;
    win_idx  = winner;
    win_time = '1;

    if (state_q == S_GO) hit_nx = hit | react_edge;

    unique case (state_q)
      S_IDLE:          if (start_edge) state_nx = S_WAIT;
      S_WAIT:          if (|react_edge) state_nx = S_FAULT;
                       else if (ms_cnt == delay_ms) state_nx = S_GO;
      S_GO:            if (&hit_nx || ms_cnt == TIMEOUT) state_nx = S_DONE;
      S_DONE, S_FAULT: if (start_edge) state_nx = S_WAIT;
      default:         state_nx = S_IDLE;
    endcase

    // First press latches the current ms count; silent players read as timeout.
    if (state_q == S_GO) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (react_edge[i] && !hit[i])
          times_nx[i*TIME_W +: TIME_W] = ms_cnt;
        else if (!hit_nx[i] && state_nx == S_DONE)
          times_nx[i*TIME_W +: TIME_W] = TIMEOUT;
      end
    end

    // Strict compare keeps the lowest index on ties; TIMEOUT is always below all-ones.
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (hit_nx[i] && times_nx[i*TIME_W +: TIME_W] < win_time) begin
        win_time = times_nx[i*TIME_W +: TIME_W];
        win_idx  = 3'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      go        <= 1'b0;
      done      <= 1'b0;
      hit       <= '0;
      fault     <= '0;
      times     <= '0;
      winner    <= '0;
      best_time <= '1;
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      lfsr      <= 16'hACE1;
      presc     <= '0;
      ms_cnt    <= '0;
      delay_ms  <= '0;
    end else begin
      sync1 <= {react_btn, start_btn};
      sync2 <= sync1;
      prev  <= sync2;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      state_q <= state_nx;
      go      <= (state_nx == S_GO);
      done    <= entering && (state_nx == S_DONE || state_nx == S_FAULT);

      if (entering) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        if (tick && ms_cnt != TIMEOUT) ms_cnt <= ms_cnt + TIME_W'(1);
      end

      unique case (state_q)
        S_GO: begin
          hit   <= hit_nx;
          times <= times_nx;
          if (state_nx == S_DONE && |hit_nx) begin
            winner <= win_idx;
            if (win_time < best_time) best_time <= win_time;
          end
        end
        S_WAIT: begin
          if (state_nx == S_FAULT) fault <= react_edge;
        end
        default: begin
          if (state_nx == S_WAIT) begin
            delay_ms <= MIN_DELAY + TIME_W'(lfsr[DELAY_RANGE_LOG2-1:0]);
            hit      <= '0;
            fault    <= '0;
            times    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core: directed rounds plus randomised press
// schedules, checked against a cycle-count model of the millisecond timeline.
module tb_reaction_timer_core;

  localparam int N_PLAYERS = 2;
  localparam int TIME_W    = 6;
  localparam int TICKS     = 4;
  localparam int MIN_DELAY = 2;
  localparam int RANGE_LOG = 2;
  localparam int TIMEOUT   = 20;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        start_btn = 1'b0;
  logic [N_PLAYERS-1:0]        react_btn = '0;
  logic                        go, done;
  logic [2:0]                  state, winner;
  logic [N_PLAYERS-1:0]        hit, fault;
  logic [N_PLAYERS*TIME_W-1:0] times;
  logic [TIME_W-1:0]           best_time;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wait_cyc, go_cyc, exp_delay;
  int exp_best = 63;
  int exp_winner = 0;
  logic [15:0] m_lfsr, m_lfsr_prev;

  reaction_timer_core #(
    .N_PLAYERS(N_PLAYERS), .TIME_W(TIME_W), .TICKS_PER_MS(TICKS),
    .MIN_DELAY_MS(MIN_DELAY), .DELAY_RANGE_LOG2(RANGE_LOG), .TIMEOUT_MS(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .go(go), .state(state), .hit(hit), .fault(fault), .times(times),
    .winner(winner), .best_time(best_time), .done(done)
  );

  always #5 clk = ~clk;

  // Edge count and the LFSR defined by its polynomial (feedback = parity of tap mask 0xB400).
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= reset ? 16'hACE1 : {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start pulse from IDLE/DONE/FAULT: WAIT is entered three edges later with cleared results.
  task automatic do_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("start_state", state, 1);
    check("start_hit", hit, 0);
    check("start_fault", fault, 0);
    check("start_times", times, 0);
    check("start_best", best_time, exp_best);
    wait_cyc  = cyc;
    exp_delay = MIN_DELAY + int'(m_lfsr_prev[RANGE_LOG-1:0]);
  endtask

  // GO is entered on the edge after the ms count reaches the latched delay.
  task automatic wait_go();
    int g;
    g = wait_cyc + TICKS * exp_delay + 1;
    while (cyc < g - 1) @(negedge clk);
    check("pre_go_state", state, 1);
    check("pre_go_led", go, 0);
    @(negedge clk);
    check("go_state", state, 2);
    check("go_led", go, 1);
    go_cyc = cyc;
  endtask

  // Press players at (ms, sub-cycle); pm < 0 means the player never presses.
  task automatic run_go(input int pm0, input int ps0, input int pm1, input int ps1);
    int pm[2], ps[2], act[2], raise_c[2], t[2];
    int done_edge, mt, ew;
    logic [1:0] eh;
    pm[0] = pm0; ps[0] = ps0; pm[1] = pm1; ps[1] = ps1;
    done_edge = go_cyc + TICKS * TIMEOUT + 1;
    for (int i = 0; i < 2; i++) begin
      act[i]     = (pm[i] < 0) ? 32'h3fff_ffff : go_cyc + TICKS * pm[i] + ps[i] + 1;
      raise_c[i] = act[i] - 3;
    end
    if (act[0] <= done_edge && act[1] <= done_edge)
      done_edge = (act[0] > act[1]) ? act[0] : act[1];
    mt = 1000;
    ew = exp_winner;
    for (int i = 0; i < 2; i++) begin
      eh[i] = (act[i] <= done_edge);
      t[i]  = eh[i] ? (act[i] - 1 - go_cyc) / TICKS : TIMEOUT;
      if (t[i] > TIMEOUT) t[i] = TIMEOUT;
      if (eh[i] && t[i] < mt) begin
        mt = t[i];
        ew = i;
      end
    end
    if (|eh) begin
      exp_winner = ew;
      if (mt < exp_best) exp_best = mt;
    end
    while (cyc < done_edge) begin
      react_btn[0] = (cyc == raise_c[0]);
      react_btn[1] = (cyc == raise_c[1]);
      start_btn    = (cyc == go_cyc + 1);
      if (cyc == done_edge - 1) begin
        check("last_go_state", state, 2);
        check("last_go_done", done, 0);
      end
      @(negedge clk);
    end
    react_btn = '0;
    start_btn = 1'b0;
    check("done_pulse", done, 1);
    check("done_state", state, 3);
    check("done_led", go, 0);
    check("done_hit", hit, eh);
    check("done_times", times, {TIME_W'(t[1]), TIME_W'(t[0])});
    check("done_winner", winner, exp_winner);
    check("done_best", best_time, exp_best);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("done_hold_state", state, 3);
  endtask

  // React press during WAIT, `off` cycles after WAIT entry.
  task automatic do_fault(input logic [1:0] mask, input int off, input bit hold);
    repeat (off) @(negedge clk);
    react_btn = mask;
    @(negedge clk);
    if (!hold) react_btn = '0;
    @(negedge clk);
    check("pre_fault_state", state, 1);
    check("pre_fault_led", go, 0);
    @(negedge clk);
    check("fault_state", state, 4);
    check("fault_mask", fault, mask);
    check("fault_done", done, 1);
    check("fault_led", go, 0);
    check("fault_hit", hit, 0);
    check("fault_best", best_time, exp_best);
    @(negedge clk);
    check("fault_one_cycle", done, 0);
    check("fault_hold_state", state, 4);
  endtask

  initial begin
    int pa, sa, pb, sb;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_go", go, 0);
    check("rst_best", best_time, 63);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_times", times, 0);
    check("rst_winner", winner, 0);
    reset = 1'b0;

    // Normal round: p1 at 5 ms, p0 at 7 ms.
    do_start();
    wait_go();
    run_go(7, 2, 5, 1);

    // False start by p0.
    do_start();
    do_fault(2'b01, 1, 1'b0);

    // Tie at 3 ms, then a round with no presses.
    do_start();
    wait_go();
    run_go(3, 0, 3, 0);
    do_start();
    wait_go();
    run_go(-1, 0, -1, 0);

    // Held p0: faults once, then stays silent through the next WAIT until re-pressed in GO.
    do_start();
    do_fault(2'b01, 0, 1'b1);
    do_start();
    wait_go();
    run_go(4, 1, 6, 3);

    for (int r = 0; r < 8; r++) begin
      pa = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 19));
      pb = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 19));
      sa = int'($urandom_range(0, 3));
      sb = int'($urandom_range(0, 3));
      do_start();
      wait_go();
      run_go(pa, sa, pb, sb);
    end

    do_start();
    do_fault(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0);
    do_start();
    wait_go();
    run_go(1, 0, -1, 0);

    // Reset in the middle of GO.
    do_start();
    wait_go();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", state, 0);
    check("mid_rst_go", go, 0);
    check("mid_rst_hit", hit, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_times", times, 0);
    check("mid_rst_winner", winner, 0);
    check("mid_rst_best", best_time, 63);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
